// File: rtl/led_breathe_pkg.sv
// Shared state encoding and default sizing for the breathing LED driver.
package led_breathe_pkg;

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HIGH = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LOW  = 2'd3
    } breathe_state_t;

    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_STEP_DIV   = 97656;
    localparam int DEF_HOLD_STEPS = 64;

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator: free-running counter, period-boundary duty latch and
// registered LED compare.
module led_pwm_gen
    import led_breathe_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_active;

    // Duty only changes on the last count so a running period never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt     <= '0;
            duty_active <= '0;
            led         <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == CNT_LAST) begin
                duty_active <= duty;
            end
            led <= en && (pwm_cnt < duty_active);
        end
    end

endmodule

// File: rtl/led_breathe.sv
// Breathing LED: step prescaler, triangle level FSM and PWM output.
// Define LED_BREATHE_GAMMA_EN for squared (perceptual) duty mapping.
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                LED,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          state
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [SW-1:0]       step_cnt;
    logic                step_tick;
    breathe_state_t      state_q;
    breathe_state_t      state_d;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [HW-1:0]       hold_cnt;
    logic [HW-1:0]       hold_d;
    logic [PWM_BITS-1:0] duty;

    assign step_tick = en && (step_cnt == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (en) begin
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RAMP_UP;
            level_q  <= '0;
            hold_cnt <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_cnt;
        if (step_tick) begin
            unique case (state_q)
                RAMP_UP: begin
                    if (level_q == LEVEL_MAX) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end
                HOLD_HIGH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (level_q == '0) begin
                        state_d = HOLD_LOW;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q - 1'b1;
                    end
                end
                HOLD_LOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_d = RAMP_UP;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    led_pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .duty(duty),
        .led (LED)
    );

    assign level = level_q;
    assign state = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe at PWM_BITS=3, STEP_DIV=4, HOLD_STEPS=2.
module tb_led_breathe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       led;
    logic [2:0] level;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] lvl;
        logic [1:0] st;
    } tick_vec_t;

    typedef struct {
        int lin;
        int gam;
    } period_vec_t;

    tick_vec_t   ticks[23];
    period_vec_t periods[11];

    led_breathe #(
        .PWM_BITS  (3),
        .STEP_DIV  (4),
        .HOLD_STEPS(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .LED  (led),
        .level(level),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check it takes effect at once, release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, " LED"}, int'(led), 0);
        chk({tag, " level"}, int'(level), 0);
        chk({tag, " state"}, int'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    function automatic int exp_duty(input period_vec_t p);
`ifdef LED_BREATHE_GAMMA_EN
        return p.gam;
`else
        return p.lin;
`endif
    endfunction

    initial begin
        int lv[23] = '{0,1,2,3,4,5,6,7,7,7,7,6,5,4,3,2,1,0,0,0,0,1,2};
        int sv[23] = '{0,0,0,0,0,0,0,0,1,1,2,2,2,2,2,2,2,2,3,3,0,0,0};
        int pl[11] = '{0,1,3,5,7,7,6,4,2,0,0};
        int pg[11] = '{0,0,1,3,6,6,4,2,0,0,0};
        logic [7:0] pat;
        int highs;

        for (int k = 0; k < 23; k++) begin
            ticks[k].lvl = 3'(lv[k]);
            ticks[k].st  = 2'(sv[k]);
        end
        for (int p = 0; p < 11; p++) begin
            periods[p].lin = pl[p];
            periods[p].gam = pg[p];
        end

        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("por LED", int'(led), 0);
        chk("por level", int'(level), 0);
        chk("por state", int'(state), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        cycles(13);
        do_reset("midrun");

        // Free run: level/state at every tick, PWM pattern of every period.
        pat = '0;
        for (int n = 1; n <= 88; n++) begin
            @(posedge clk);
            #1;
            pat = {led, pat[7:1]};
            if (n % 4 == 0) begin
                chk($sformatf("tick%0d level", n / 4), int'(level),
                    int'(ticks[n / 4].lvl));
                chk($sformatf("tick%0d state", n / 4), int'(state),
                    int'(ticks[n / 4].st));
            end else if (n % 4 == 3) begin
                chk($sformatf("pre-tick%0d level", n / 4 + 1), int'(level),
                    int'(ticks[n / 4].lvl));
            end
            if (n % 8 == 0) begin
                chk($sformatf("period%0d pattern", n / 8 - 1), int'(pat),
                    (1 << exp_duty(periods[n / 8 - 1])) - 1);
                pat = '0;
            end
        end

        // en low for 37 cycles while ramping down at level 5.
        do_reset("pre-en");
        cycles(48);
        chk("en-test level", int'(level), 5);
        chk("en-test state", int'(state), 2);
        cycles(1);
        chk("en-test LED before drop", int'(led), 1);
        @(negedge clk);
        en = 1'b0;
        cycles(1);
        chk("en-drop LED next cycle", int'(led), 0);
        highs = 0;
        for (int i = 0; i < 36; i++) begin
            cycles(1);
            if (led) highs++;
        end
        chk("en-low LED highs", highs, 0);
        chk("en-low level held", int'(level), 5);
        chk("en-low state held", int'(state), 2);
        @(negedge clk);
        en = 1'b1;
        cycles(2);
        chk("resume level before tick", int'(level), 5);
        cycles(1);
        chk("resume level after tick", int'(level), 4);
        chk("resume state", int'(state), 2);
        chk("resume LED", int'(led), 1);

        do_reset("rampdown");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
